mips_fetch: RTL and testbench
=============================

MIPS_FETCH -- requirements
Module: mips_fetch

Interface
REQ-001 Parameter RESET_VECTOR, default 32'hBFC00000, meaning the first fetch address after reset.
REQ-002 Parameter HALT_ADDR, default 32'h00000000, meaning a redirect to this address requests a CPU halt.
REQ-003 clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 stall  input  1  downstream not ready; freezes the PC and the fetch register.
REQ-006 redirect_valid  input  1  decode has resolved a taken branch or jump for the instruction in fetch_instr.
REQ-007 redirect_target  input  32  byte address of the branch or jump target.
REQ-008 instr_address  output  32  address driven to the combinational instruction memory; equals PC.
REQ-009 instr_readdata  input  32  instruction word returned combinationally in the same cycle.
REQ-010 fetch_valid  output  1  fetch_instr, fetch_pc and fetch_pc_plus8 hold a live instruction.
REQ-011 fetch_instr  output  32  registered instruction word (IF/ID register).
REQ-012 fetch_pc  output  32  address of fetch_instr.
REQ-013 fetch_pc_plus8  output  32  fetch_pc+8, the link address for jal/jalr/bgezal.
REQ-014 active  output  1  high while the CPU is running; low once halted.
REQ-015 fetch_error  output  1  sticky flag set by a misaligned redirect target.

Function
REQ-016 The state machine SHALL have the states RUN, DRAIN and HALTED.
REQ-017 RUN, stall=0, no redirect: fetch register <= {instr_readdata, PC}; fetch_valid<=1; PC<=PC+4 (32-bit wrap, no carry-out).
REQ-018 RUN, stall=0, redirect_valid=1, target!=HALT_ADDR, target[1:0]==0: fetch register <= current word (the delay slot); PC<=redirect_target.
REQ-019 Branch delay slot: the instruction at branch_pc+4 SHALL always be issued once; fetch never squashes it.
REQ-020 RUN, stall=0, redirect_target==HALT_ADDR: delay slot latched; PC<=HALT_ADDR; state<=DRAIN.
REQ-021 DRAIN, stall=0: fetch_valid<=0; active<=0; state<=HALTED; a redirect in DRAIN SHALL be ignored.
REQ-022 HALTED: all registers hold; fetch_valid=0; active=0; only reset leaves HALTED.
REQ-023 Any redirect with target[1:0]!=0: fetch_error<=1; fetch_valid<=0; active<=0; state<=HALTED; the delay slot is dropped.
REQ-024 stall=1 in any state: PC, fetch register, fetch_valid and state hold; redirect_valid is ignored, so decode holds it until stall=0.
REQ-025 Fetch latency SHALL be one cycle: the word at instr_address in cycle N appears on fetch_instr in cycle N+1.
REQ-026 instr_address SHALL be a direct, glitch-free copy of the PC register; no combinational path from redirect_* to it.
REQ-027 fetch_pc_plus8 SHALL be registered alongside fetch_pc, computed modulo 2^32.

Reset
REQ-028 On a clock edge with reset=1: PC=RESET_VECTOR, state=RUN, fetch_valid=0, fetch_instr=0, fetch_pc=0, fetch_pc_plus8=0, active=1, fetch_error=0.
REQ-029 Reset SHALL take priority over stall and redirect in every state, including mid-DRAIN and HALTED.

Structure
REQ-030 RESET_VECTOR, HALT_ADDR and the state enum SHALL live in the shared package mips_pkg.
REQ-031 No sub-module is natural; PC, next-PC mux, FSM and IF/ID register SHALL sit in one module.

Verification
REQ-032 Reset, then run 3 cycles -> instr_address BFC00000, BFC00004, BFC00008; fetch_valid 0,1,1; fetch_pc BFC00000, BFC00004.
REQ-033 Branch at BFC00004 redirected to 20000000 while fetch_instr holds it -> fetch_pc sequence BFC00004, BFC00008, 20000000, 20000004.
REQ-034 jr r0 at 20000008 (redirect to 0) -> delay slot 2000000C issued with fetch_valid=1; active=0 one cycle later; outputs then frozen.
REQ-035 stall=1 for 3 cycles with redirect_valid held -> PC and fetch_instr unchanged; redirect applied on the first cycle with stall=0.
REQ-036 redirect_target=20000002 -> fetch_error=1, active=0, fetch_valid=0 next cycle.
REQ-037 reset asserted in DRAIN and in HALTED -> next instr_address=BFC00000, active=1, fetch_error=0.

Source files
------------

// File: rtl/mips_pkg.sv
// ============================================================================
// mips_pkg : shared constants for the MIPS fetch stage
// Rev 1.0  : initial release
// ============================================================================
`default_nettype none

package mips_pkg;

  localparam logic [31:0] RESET_VECTOR = 32'hBFC0_0000;
  localparam logic [31:0] HALT_ADDR    = 32'h0000_0000;

  typedef logic [1:0] fetch_state_t;
  localparam fetch_state_t ST_RUN    = 2'd0;
  localparam fetch_state_t ST_DRAIN  = 2'd1;
  localparam fetch_state_t ST_HALTED = 2'd2;

  function automatic logic is_misaligned(input logic [31:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mips_fetch_if.sv
// ============================================================================
// mips_fetch_if : fetch-stage bus (imem port, decode handshake, IF/ID outputs)
// Rev 1.0       : initial release
// ============================================================================
`default_nettype none

interface mips_fetch_if;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic [31:0] instr_address;
  logic [31:0] instr_readdata;
  logic        fetch_valid;
  logic [31:0] fetch_instr;
  logic [31:0] fetch_pc;
  logic [31:0] fetch_pc_plus8;
  logic        active;
  logic        fetch_error;

  modport master (
    input  stall, redirect_valid, redirect_target, instr_readdata,
    output instr_address, fetch_valid, fetch_instr, fetch_pc,
           fetch_pc_plus8, active, fetch_error
  );

  modport slave (
    output stall, redirect_valid, redirect_target, instr_readdata,
    input  instr_address, fetch_valid, fetch_instr, fetch_pc,
           fetch_pc_plus8, active, fetch_error
  );
endinterface

`default_nettype wire

// File: rtl/mips_fetch.sv
// ============================================================================
// mips_fetch : PC, next-PC mux, RUN/DRAIN/HALTED FSM and IF/ID register
// Rev 1.0    : initial release
// ============================================================================
`default_nettype none

module mips_fetch #(
  parameter logic [31:0] RESET_VECTOR = mips_pkg::RESET_VECTOR,
  parameter logic [31:0] HALT_ADDR    = mips_pkg::HALT_ADDR
) (
  input  wire logic     clk,
  input  wire logic     reset,
  mips_fetch_if.master  bus
);
  import mips_pkg::*;

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  instr_q, instr_d;
  logic [31:0]  fpc_q, fpc_d;
  logic [31:0]  fpc8_q, fpc8_d;
  logic         valid_q, valid_d;
  logic         active_q, active_d;
  logic         err_q, err_d;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    fpc_d    = fpc_q;
    fpc8_d   = fpc8_q;
    valid_d  = valid_q;
    active_d = active_q;
    err_d    = err_q;
    if (!bus.stall) begin
      case (state_q)
        ST_RUN: begin
          if (bus.redirect_valid && is_misaligned(bus.redirect_target)) begin
            err_d    = 1'b1;
            valid_d  = 1'b0;
            active_d = 1'b0;
            state_d  = ST_HALTED;
          end else begin
            // The current word is always issued, so a redirect keeps its delay slot.
            instr_d = bus.instr_readdata;
            fpc_d   = pc_q;
            fpc8_d  = pc_q + 32'd8;
            valid_d = 1'b1;
            if (bus.redirect_valid) begin
              pc_d = bus.redirect_target;
              if (bus.redirect_target == HALT_ADDR) state_d = ST_DRAIN;
            end else begin
              pc_d = pc_q + 32'd4;
            end
          end
        end
        ST_DRAIN: begin
          valid_d  = 1'b0;
          active_d = 1'b0;
          state_d  = ST_HALTED;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_RUN;
      pc_q     <= RESET_VECTOR;
      instr_q  <= '0;
      fpc_q    <= '0;
      fpc8_q   <= '0;
      valid_q  <= 1'b0;
      active_q <= 1'b1;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      fpc_q    <= fpc_d;
      fpc8_q   <= fpc8_d;
      valid_q  <= valid_d;
      active_q <= active_d;
      err_q    <= err_d;
    end
  end

  assign bus.instr_address  = pc_q;
  assign bus.fetch_valid    = valid_q;
  assign bus.fetch_instr    = instr_q;
  assign bus.fetch_pc       = fpc_q;
  assign bus.fetch_pc_plus8 = fpc8_q;
  assign bus.active         = active_q;
  assign bus.fetch_error    = err_q;

endmodule

`default_nettype wire

// File: tb/tb_mips_fetch.sv
// ============================================================================
// tb_mips_fetch : directed-vector bench for mips_fetch
// Rev 1.0       : initial release
// ============================================================================
`default_nettype none

module tb_mips_fetch;
  logic clk = 1'b0;
  logic reset;
  int   n_vec = 0;
  int   n_err = 0;

  mips_fetch_if bus();

  mips_fetch dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Instruction memory: each word is its own address with a fixed XOR tag.
  assign bus.instr_readdata = bus.instr_address ^ 32'hA5A5_0000;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rst, input logic stl, input logic rv, input logic [31:0] tgt);
    reset               = rst;
    bus.stall           = stl;
    bus.redirect_valid  = rv;
    bus.redirect_target = tgt;
  endtask

  initial begin
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    step();
    chk("rst_addr",   bus.instr_address, 32'hBFC0_0000);
    chk("rst_valid",  bus.fetch_valid,   32'd0);
    chk("rst_active", bus.active,        32'd1);
    chk("rst_err",    bus.fetch_error,   32'd0);
    chk("rst_instr",  bus.fetch_instr,   32'd0);
    chk("rst_pc",     bus.fetch_pc,      32'd0);
    chk("rst_pc8",    bus.fetch_pc_plus8, 32'd0);

    drive(1'b0, 1'b0, 1'b0, 32'h0);
    step();
    chk("run1_addr",  bus.instr_address, 32'hBFC0_0004);
    chk("run1_valid", bus.fetch_valid,   32'd1);
    chk("run1_pc",    bus.fetch_pc,      32'hBFC0_0000);
    chk("run1_instr", bus.fetch_instr,   32'h1A65_0000);
    chk("run1_pc8",   bus.fetch_pc_plus8, 32'hBFC0_0008);
    step();
    chk("run2_addr",  bus.instr_address, 32'hBFC0_0008);
    chk("run2_valid", bus.fetch_valid,   32'd1);
    chk("run2_pc",    bus.fetch_pc,      32'hBFC0_0004);

    // Branch at BFC00004 is in fetch_instr: redirect to 20000000.
    drive(1'b0, 1'b0, 1'b1, 32'h2000_0000);
    step();
    chk("br_slot_pc",  bus.fetch_pc,      32'hBFC0_0008);
    chk("br_slot_vld", bus.fetch_valid,   32'd1);
    chk("br_addr",     bus.instr_address, 32'h2000_0000);
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    step();
    chk("br_tgt_pc",   bus.fetch_pc,      32'h2000_0000);
    step();
    chk("br_tgt4_pc",  bus.fetch_pc,      32'h2000_0004);
    chk("br_tgt4_ins", bus.fetch_instr,   32'h85A5_0004);

    // Stall three cycles with a redirect held; nothing moves.
    drive(1'b0, 1'b1, 1'b1, 32'h3000_0000);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_addr",  bus.instr_address, 32'h2000_0008);
      chk("stall_instr", bus.fetch_instr,   32'h85A5_0004);
      chk("stall_pc",    bus.fetch_pc,      32'h2000_0004);
    end
    bus.stall = 1'b0;
    step();
    chk("unstall_addr", bus.instr_address, 32'h3000_0000);
    chk("unstall_pc",   bus.fetch_pc,      32'h2000_0008);
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    step();
    chk("post_pc",      bus.fetch_pc,      32'h3000_0000);

    // jr r0: delay slot issued, then drain; a redirect during DRAIN is ignored.
    drive(1'b0, 1'b0, 1'b1, 32'h0000_0000);
    step();
    chk("halt_slot_pc",  bus.fetch_pc,      32'h3000_0004);
    chk("halt_slot_ins", bus.fetch_instr,   32'h95A5_0004);
    chk("halt_slot_vld", bus.fetch_valid,   32'd1);
    chk("halt_slot_act", bus.active,        32'd1);
    chk("halt_addr",     bus.instr_address, 32'h0);
    drive(1'b0, 1'b0, 1'b1, 32'h5000_0000);
    step();
    chk("drain_vld",  bus.fetch_valid,   32'd0);
    chk("drain_act",  bus.active,        32'd0);
    chk("drain_addr", bus.instr_address, 32'h0);
    drive(1'b0, 1'b0, 1'b1, 32'h1234_5678);
    step();
    step();
    chk("frz_addr", bus.instr_address, 32'h0);
    chk("frz_pc",   bus.fetch_pc,      32'h3000_0004);
    chk("frz_vld",  bus.fetch_valid,   32'd0);
    chk("frz_err",  bus.fetch_error,   32'd0);

    // Reset out of HALTED.
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    step();
    chk("rsth_addr", bus.instr_address, 32'hBFC0_0000);
    chk("rsth_act",  bus.active,        32'd1);

    // Reset mid-DRAIN, with stall and redirect asserted.
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    step();
    drive(1'b0, 1'b0, 1'b1, 32'h0);
    step();
    chk("drn_pc", bus.fetch_pc, 32'hBFC0_0004);
    drive(1'b1, 1'b1, 1'b1, 32'h0);
    step();
    chk("rstd_addr", bus.instr_address, 32'hBFC0_0000);
    chk("rstd_act",  bus.active,        32'd1);
    chk("rstd_vld",  bus.fetch_valid,   32'd0);
    chk("rstd_pc",   bus.fetch_pc,      32'd0);

    // Wrap of PC and link address at the top of the address space.
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    step();
    drive(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
    step();
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    step();
    chk("wrap_pc",   bus.fetch_pc,       32'hFFFF_FFFC);
    chk("wrap_pc8",  bus.fetch_pc_plus8, 32'h0000_0004);
    chk("wrap_addr", bus.instr_address,  32'h0000_0000);

    // Misaligned redirect.
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    step();
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    step();
    drive(1'b0, 1'b0, 1'b1, 32'h2000_0002);
    step();
    chk("mis_err",  bus.fetch_error,   32'd1);
    chk("mis_act",  bus.active,        32'd0);
    chk("mis_vld",  bus.fetch_valid,   32'd0);
    chk("mis_pc",   bus.fetch_pc,      32'hBFC0_0000);
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    step();
    chk("mis_hold", bus.fetch_error,   32'd1);
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    step();
    chk("rste_err",  bus.fetch_error,   32'd0);
    chk("rste_act",  bus.active,        32'd1);
    chk("rste_addr", bus.instr_address, 32'hBFC0_0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
